// File: rtl/reg_dump_controller.sv
// Debug register-bank dump sequencer.
// While the core is halted, walks every register through the bank's port-A
// debug address mux, latches each value and streams it out MSB byte first
// over a single-strobe / single-done transmitter handshake.
module reg_dump_controller #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               halted_i,
    input  logic               abort_i,
    input  logic [NB_DATA-1:0] data_ra_i,
    output logic               select_debug_or_wireA_o,
    output logic [NB_REG-1:0]  addr_reg_debug_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_done_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int N_BYTES = NB_DATA / 8;
    localparam int NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(N_BYTES - 1);
    localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LATCH,
        ST_SEND,
        ST_WAIT_TX,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NB_REG-1:0]    r_reg_idx;
    logic [NB_BIDX-1:0]   r_byte_idx;
    logic [NB_DATA-1:0]   r_shift;
    logic                 w_accept;
    logic                 w_tx_ack;

    // Dump request only counts while the core is halted.
    assign w_accept = start_i & halted_i;
    // A byte completes only in WAIT_TX, and an abort overrides it.
    assign w_tx_ack = (r_state == ST_WAIT_TX) & tx_done_i & ~abort_i;

    // State register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Register/byte counters and the outgoing shift register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_reg_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_accept) begin
                r_reg_idx  <= '0;
                r_byte_idx <= '0;
            end
            if ((r_state == ST_LATCH) && !abort_i) begin
                r_shift    <= data_ra_i;
                r_byte_idx <= '0;
            end
            if (w_tx_ack) begin
                r_shift <= r_shift << 8;
                if (r_byte_idx != LAST_BYTE) begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                end else if (r_reg_idx != LAST_REG) begin
                    r_reg_idx <= r_reg_idx + 1'b1;
                end
            end
        end
    end

    // Next-state logic; outputs decode from the current state only.
    always_comb begin
        w_next_state            = r_state;
        select_debug_or_wireA_o = 1'b0;
        tx_start_o              = 1'b0;
        tx_data_o               = '0;
        busy_o                  = (r_state != ST_IDLE);
        done_o                  = 1'b0;
        addr_reg_debug_o        = r_reg_idx;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_SELECT;
                end
            end
            ST_SELECT: begin
                select_debug_or_wireA_o = 1'b1;
                w_next_state            = ST_LATCH;
            end
            ST_LATCH: begin
                select_debug_or_wireA_o = 1'b1;
                w_next_state            = ST_SEND;
            end
            ST_SEND: begin
                select_debug_or_wireA_o = 1'b1;
                tx_start_o              = 1'b1;
                tx_data_o               = r_shift[NB_DATA-1 -: 8];
                w_next_state            = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                select_debug_or_wireA_o = 1'b1;
                tx_data_o               = r_shift[NB_DATA-1 -: 8];
                if (tx_done_i) begin
                    if (r_byte_idx != LAST_BYTE) begin
                        w_next_state = ST_SEND;
                    end else if (r_reg_idx != LAST_REG) begin
                        w_next_state = ST_SELECT;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_o       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Abort wins over every transition out of a busy state.
        if (abort_i && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_reg_dump_controller.sv
// Self-checking bench for reg_dump_controller: a single-cycle vector table,
// then whole dumps compared against a byte stream computed from a bank array.
module tb_reg_dump_controller;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int N_REGS  = 32;

    logic               clock_i;
    logic               reset_i;
    logic               start_i;
    logic               halted_i;
    logic               abort_i;
    logic [NB_DATA-1:0] data_ra_i;
    logic               select_debug_or_wireA_o;
    logic [NB_REG-1:0]  addr_reg_debug_o;
    logic [7:0]         tx_data_o;
    logic               tx_start_o;
    logic               tx_done_i;
    logic               busy_o;
    logic               done_o;

    logic [NB_DATA-1:0] bank [0:N_REGS-1];

    int checks = 0;
    int errors = 0;

    reg_dump_controller #(
        .NB_DATA(NB_DATA),
        .NB_REG (NB_REG),
        .N_REGS (N_REGS)
    ) dut (
        .clock_i                (clock_i),
        .reset_i                (reset_i),
        .start_i                (start_i),
        .halted_i               (halted_i),
        .abort_i                (abort_i),
        .data_ra_i              (data_ra_i),
        .select_debug_or_wireA_o(select_debug_or_wireA_o),
        .addr_reg_debug_o       (addr_reg_debug_o),
        .tx_data_o              (tx_data_o),
        .tx_start_o             (tx_start_o),
        .tx_done_i              (tx_done_i),
        .busy_o                 (busy_o),
        .done_o                 (done_o)
    );

    // Register bank read port: garbage unless the debug mux is selected.
    assign data_ra_i = select_debug_or_wireA_o ? bank[addr_reg_debug_o] : 32'hDEAD_BEEF;

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},   select_debug_or_wireA_o, 0);
        chk({tag, "_addr"},  addr_reg_debug_o, 0);
        chk({tag, "_txd"},   tx_data_o, 0);
        chk({tag, "_txs"},   tx_start_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_done"},  done_o, 0);
    endtask

    task automatic load_pattern();
        for (int k = 0; k < N_REGS; k++) bank[k] = 32'hA0B0_C000 + k;
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // Run one dump. dmode: 0 = done 3 cycles after strobe, 1 = random 1..4,
    // 2 = done on first WAIT_TX cycle. stop_byte >= 0 ends the dump in the
    // WAIT_TX of that byte, by abort_i or (by_reset) by async reset.
    task automatic run_dump(input int dmode, input bit noise, input int stop_byte,
                            input bit by_reset, input string tag);
        logic [7:0] exp_q[$];
        int         exp_r[$];
        int pend, nbytes, ndone, done_cyc, tot, t, stop_t, late, b2b, d;
        bit armed, stopped, fin, prev_txs;
        pend = 0; nbytes = 0; ndone = 0; done_cyc = -1; tot = 0; stop_t = 0;
        late = 0; b2b = 0; armed = 0; stopped = 0; fin = 0; prev_txs = 0;

        for (int k = 0; k < N_REGS; k++) begin
            for (int b = 0; b < NB_DATA / 8; b++) begin
                exp_q.push_back(8'((bank[k] >> (NB_DATA - 8 - 8 * b)) & 32'hFF));
                exp_r.push_back(k);
            end
        end

        start_i = 1'b1; halted_i = 1'b1; abort_i = 1'b0; tx_done_i = 1'b0;
        step();
        t = 1;
        start_i = 1'b0;
        chk({tag, "_busy_rise"}, busy_o, 1);

        while (!fin && t < 4000) begin
            tx_done_i = 1'b0;
            abort_i   = 1'b0;
            if (noise) begin
                start_i  = 1'($urandom_range(0, 1));
                halted_i = 1'($urandom_range(0, 1));
            end
            if (stopped) begin
                start_i = 1'b0;
                if (by_reset) reset_i = 1'b1;
                if (t == stop_t + 1) begin
                    chk({tag, "_stop_busy"}, busy_o, 0);
                    chk({tag, "_stop_sel"}, select_debug_or_wireA_o, 0);
                end
                if (tx_start_o) late++;
                if (done_o) ndone++;
                if (t >= stop_t + 30) fin = 1'b1;
            end else begin
                if (tx_start_o && prev_txs) b2b++;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) tx_done_i = 1'b1;
                end
                if (tx_start_o) begin
                    if (exp_q.size() == 0) begin
                        chk({tag, "_extra_strobe"}, tx_start_o, 0);
                    end else begin
                        chk($sformatf("%s_byte%0d", tag, nbytes), tx_data_o, exp_q.pop_front());
                        chk($sformatf("%s_addr%0d", tag, nbytes), addr_reg_debug_o, exp_r.pop_front());
                        chk($sformatf("%s_sel%0d", tag, nbytes), select_debug_or_wireA_o, 1);
                    end
                    d = (dmode == 0) ? 3 : (dmode == 2) ? 1 : int'($urandom_range(1, 4));
                    tot += 1 + d;
                    pend = d;
                    if (noise && $urandom_range(0, 1) == 1) tx_done_i = 1'b1;
                    if (nbytes == stop_byte) armed = 1'b1;
                    nbytes++;
                end else if (armed) begin
                    armed   = 1'b0;
                    stopped = 1'b1;
                    stop_t  = t;
                    if (by_reset) begin
                        #2 reset_i = 1'b0;
                        #1;
                        chk_all_zero({tag, "_async"});
                    end else begin
                        abort_i = 1'b1;
                    end
                end
                if (done_o) begin
                    ndone++;
                    done_cyc = t;
                end
                if (!stopped && t > 1 && !busy_o) fin = 1'b1;
            end
            if (fin) start_i = 1'b0;
            prev_txs = tx_start_o;
            step();
            t++;
        end

        chk({tag, "_finished"}, fin, 1);
        start_i = 1'b0; halted_i = 1'b1; abort_i = 1'b0; tx_done_i = 1'b0;
        if (stopped) begin
            chk({tag, "_late_strobes"}, late, 0);
            chk({tag, "_no_done"}, ndone, 0);
            chk({tag, "_bytes_sent"}, nbytes, stop_byte + 1);
        end else begin
            chk({tag, "_missing_bytes"}, exp_q.size(), 0);
            chk({tag, "_done_pulses"}, ndone, 1);
            chk({tag, "_done_cycle"}, done_cyc, 2 * N_REGS + tot + 1);
            chk({tag, "_b2b_strobes"}, b2b, 0);
        end
    endtask

    typedef struct {
        bit         st, hl, ab, td;
        bit         busy, sel, txs, dn;
        bit         ck_d;
        logic [7:0] txd;
    } vec_t;

    vec_t tv [14];

    initial begin
        reset_i = 1'b0; start_i = 1'b0; halted_i = 1'b0; abort_i = 1'b0; tx_done_i = 1'b0;
        load_pattern();

        // Reset state and release
        #12;
        chk_all_zero("reset");
        step();
        reset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("idle_busy%0d", i), busy_o, 0);
        end

        // Single-cycle vectors: inputs this cycle, outputs after the edge
        tv[0]  = '{1,0,0,0, 0,0,0,0, 0,8'h00};
        tv[1]  = '{0,1,0,0, 0,0,0,0, 0,8'h00};
        tv[2]  = '{0,0,1,0, 0,0,0,0, 0,8'h00};
        tv[3]  = '{0,0,0,1, 0,0,0,0, 0,8'h00};
        tv[4]  = '{1,1,0,0, 1,1,0,0, 0,8'h00};
        tv[5]  = '{1,1,0,1, 1,1,0,0, 0,8'h00};
        tv[6]  = '{0,1,0,1, 1,1,1,0, 1,8'hA0};
        tv[7]  = '{0,1,0,1, 1,1,0,0, 1,8'hA0};
        tv[8]  = '{0,1,0,0, 1,1,0,0, 1,8'hA0};
        tv[9]  = '{0,1,0,1, 1,1,1,0, 1,8'hB0};
        tv[10] = '{0,1,1,0, 0,0,0,0, 0,8'h00};
        tv[11] = '{1,1,0,0, 1,1,0,0, 0,8'h00};
        tv[12] = '{0,1,1,0, 0,0,0,0, 0,8'h00};
        tv[13] = '{0,1,0,0, 0,0,0,0, 0,8'h00};
        for (int i = 0; i < 14; i++) begin
            start_i = tv[i].st; halted_i = tv[i].hl; abort_i = tv[i].ab; tx_done_i = tv[i].td;
            step();
            chk($sformatf("vec%0d_busy", i), busy_o, tv[i].busy);
            chk($sformatf("vec%0d_sel", i), select_debug_or_wireA_o, tv[i].sel);
            chk($sformatf("vec%0d_txs", i), tx_start_o, tv[i].txs);
            chk($sformatf("vec%0d_done", i), done_o, tv[i].dn);
            if (tv[i].ck_d) chk($sformatf("vec%0d_txd", i), tx_data_o, tv[i].txd);
            if (tv[i].sel) chk($sformatf("vec%0d_addr", i), addr_reg_debug_o, 0);
        end
        start_i = 1'b0; abort_i = 1'b0; tx_done_i = 1'b0;
        step();

        // Full dump, done 3 cycles after each strobe
        run_dump(0, 1'b0, -1, 1'b0, "full");

        // Random bank, random done delay, noisy start/halted, done during SEND
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N_REGS; k++) bank[k] = $urandom;
            run_dump(1, 1'b1, -1, 1'b0, $sformatf("rand%0d", r));
        end
        load_pattern();

        // Abort in WAIT_TX of reg 5 byte 2 (coincides with tx_done), then restart
        run_dump(2, 1'b0, 5 * 4 + 2, 1'b0, "abort");
        run_dump(2, 1'b0, -1, 1'b0, "b2b");

        // Async reset in WAIT_TX of reg 31 byte 3
        run_dump(0, 1'b0, N_REGS * 4 - 1, 1'b1, "rst");
        step();
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_done", done_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
